// File: rtl/apb4_master_arbiter.sv
// Two-requester APB4 master: round-robin arbitration in IDLE, one APB transfer
// at a time, with a bounded ACCESS wait and a one-cycle response pulse to the owner.
module apb4_master_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 16
) (
    input  logic                    PCLK,
    input  logic                    PRESETn,
    input  logic                    req0_valid,
    input  logic                    req0_write,
    input  logic [ADDR_WIDTH-1:0]   req0_addr,
    input  logic [DATA_WIDTH-1:0]   req0_wdata,
    input  logic [DATA_WIDTH/8-1:0] req0_strb,
    input  logic [2:0]              req0_prot,
    output logic                    req0_ready,
    output logic                    rsp0_valid,
    output logic [DATA_WIDTH-1:0]   rsp0_rdata,
    output logic                    rsp0_err,
    input  logic                    req1_valid,
    input  logic                    req1_write,
    input  logic [ADDR_WIDTH-1:0]   req1_addr,
    input  logic [DATA_WIDTH-1:0]   req1_wdata,
    input  logic [DATA_WIDTH/8-1:0] req1_strb,
    input  logic [2:0]              req1_prot,
    output logic                    req1_ready,
    output logic                    rsp1_valid,
    output logic [DATA_WIDTH-1:0]   rsp1_rdata,
    output logic                    rsp1_err,
    output logic                    PSEL,
    output logic                    PENABLE,
    output logic                    PWRITE,
    output logic [ADDR_WIDTH-1:0]   PADDR,
    output logic [DATA_WIDTH-1:0]   PWDATA,
    output logic [DATA_WIDTH/8-1:0] PSTRB,
    output logic [2:0]              PPROT,
    input  logic                    PREADY,
    input  logic [DATA_WIDTH-1:0]   PRDATA,
    input  logic                    PSLVERR
);

    localparam int STRB_WIDTH = DATA_WIDTH / 8;
    localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1);
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                  state_r, state_next_s;
    logic                    ptr_r;
    logic                    owner_r;
    logic [CNT_WIDTH-1:0]    wait_cnt_r;
    logic                    psel_r, penable_r, pwrite_r;
    logic [ADDR_WIDTH-1:0]   paddr_r;
    logic [DATA_WIDTH-1:0]   pwdata_r;
    logic [STRB_WIDTH-1:0]   pstrb_r;
    logic [2:0]              pprot_r;
    logic                    rsp0_valid_r, rsp0_err_r, rsp1_valid_r, rsp1_err_r;
    logic [DATA_WIDTH-1:0]   rsp0_rdata_r, rsp1_rdata_r;

    logic                    grant0_s, grant1_s, accept_s;
    logic                    done_s, timeout_s, finish_s;
    logic                    sel_write_s;
    logic [ADDR_WIDTH-1:0]   sel_addr_s;
    logic [DATA_WIDTH-1:0]   sel_wdata_s;
    logic [STRB_WIDTH-1:0]   sel_strb_s;
    logic [2:0]              sel_prot_s;

    // Arbitration, transfer completion and next-state decode
    always_comb begin
        grant0_s     = 1'b0;
        grant1_s     = 1'b0;
        done_s       = 1'b0;
        timeout_s    = 1'b0;
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (req0_valid && req1_valid) begin
                    grant0_s = ~ptr_r;
                    grant1_s = ptr_r;
                end else if (req0_valid) begin
                    grant0_s = 1'b1;
                end else if (req1_valid) begin
                    grant1_s = 1'b1;
                end else begin
                    grant0_s = 1'b0;
                    grant1_s = 1'b0;
                end
                if (grant0_s || grant1_s) begin
                    state_next_s = ST_SETUP;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_SETUP: begin
                state_next_s = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    done_s       = 1'b1;
                    state_next_s = ST_IDLE;
                end else if (wait_cnt_r == CNT_LAST) begin
                    timeout_s    = 1'b1;
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_ACCESS;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Field mux of the granted requester; reads never carry byte strobes
    always_comb begin
        if (grant1_s) begin
            sel_write_s = req1_write;
            sel_addr_s  = req1_addr;
            sel_wdata_s = req1_wdata;
            sel_strb_s  = req1_write ? req1_strb : {STRB_WIDTH{1'b0}};
            sel_prot_s  = req1_prot;
        end else begin
            sel_write_s = req0_write;
            sel_addr_s  = req0_addr;
            sel_wdata_s = req0_wdata;
            sel_strb_s  = req0_write ? req0_strb : {STRB_WIDTH{1'b0}};
            sel_prot_s  = req0_prot;
        end
    end

    assign accept_s = grant0_s | grant1_s;
    assign finish_s = done_s | timeout_s;

    // FSM state, pointer, APB request registers and wait counter
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_r    <= ST_IDLE;
            ptr_r      <= 1'b0;
            owner_r    <= 1'b0;
            wait_cnt_r <= {CNT_WIDTH{1'b0}};
            psel_r     <= 1'b0;
            penable_r  <= 1'b0;
            pwrite_r   <= 1'b0;
            paddr_r    <= {ADDR_WIDTH{1'b0}};
            pwdata_r   <= {DATA_WIDTH{1'b0}};
            pstrb_r    <= {STRB_WIDTH{1'b0}};
            pprot_r    <= 3'b000;
        end else begin
            state_r   <= state_next_s;
            psel_r    <= (state_next_s != ST_IDLE);
            penable_r <= (state_next_s == ST_ACCESS);
            if (accept_s) begin
                owner_r  <= grant1_s;
                ptr_r    <= ~grant1_s;
                pwrite_r <= sel_write_s;
                paddr_r  <= sel_addr_s;
                pwdata_r <= sel_wdata_s;
                pstrb_r  <= sel_strb_s;
                pprot_r  <= sel_prot_s;
            end
            if (state_r == ST_SETUP) begin
                wait_cnt_r <= {CNT_WIDTH{1'b0}};
            end else if ((state_r == ST_ACCESS) && !PREADY) begin
                wait_cnt_r <= wait_cnt_r + CNT_WIDTH'(1);
            end
        end
    end

    // Response pulse to the owner; timeouts and writes return zero data
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp0_valid_r <= 1'b0;
            rsp0_err_r   <= 1'b0;
            rsp0_rdata_r <= {DATA_WIDTH{1'b0}};
            rsp1_valid_r <= 1'b0;
            rsp1_err_r   <= 1'b0;
            rsp1_rdata_r <= {DATA_WIDTH{1'b0}};
        end else begin
            rsp0_valid_r <= finish_s && !owner_r;
            rsp1_valid_r <= finish_s && owner_r;
            if (finish_s && !owner_r) begin
                rsp0_err_r   <= timeout_s | PSLVERR;
                rsp0_rdata_r <= (done_s && !pwrite_r) ? PRDATA : {DATA_WIDTH{1'b0}};
            end
            if (finish_s && owner_r) begin
                rsp1_err_r   <= timeout_s | PSLVERR;
                rsp1_rdata_r <= (done_s && !pwrite_r) ? PRDATA : {DATA_WIDTH{1'b0}};
            end
        end
    end

    assign req0_ready = grant0_s;
    assign req1_ready = grant1_s;
    assign PSEL       = psel_r;
    assign PENABLE    = penable_r;
    assign PWRITE     = pwrite_r;
    assign PADDR      = paddr_r;
    assign PWDATA     = pwdata_r;
    assign PSTRB      = pstrb_r;
    assign PPROT      = pprot_r;
    assign rsp0_valid = rsp0_valid_r;
    assign rsp0_err   = rsp0_err_r;
    assign rsp0_rdata = rsp0_rdata_r;
    assign rsp1_valid = rsp1_valid_r;
    assign rsp1_err   = rsp1_err_r;
    assign rsp1_rdata = rsp1_rdata_r;

endmodule

// File: tb/tb_apb4_master_arbiter.sv
// Directed bench for apb4_master_arbiter: single write, contention, wait states,
// timeout and reset during ACCESS, all against hand-computed values.
module tb_apb4_master_arbiter;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        req0_valid, req0_write, req1_valid, req1_write;
    logic [31:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
    logic [3:0]  req0_strb, req1_strb;
    logic [2:0]  req0_prot, req1_prot;
    logic        req0_ready, req1_ready;
    logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
    logic [31:0] rsp0_rdata, rsp1_rdata;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [31:0] PADDR, PWDATA, PRDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;

    int checks   = 0;
    int failures = 0;
    int cnt0, cnt1, g;

    apb4_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(16)) dut (
        .PCLK(PCLK), .PRESETn(PRESETn),
        .req0_valid(req0_valid), .req0_write(req0_write), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_strb(req0_strb), .req0_prot(req0_prot),
        .req0_ready(req0_ready), .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp0_err(rsp0_err),
        .req1_valid(req1_valid), .req1_write(req1_write), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_strb(req1_strb), .req1_prot(req1_prot),
        .req1_ready(req1_ready), .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .rsp1_err(rsp1_err),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PSTRB(PSTRB), .PPROT(PPROT),
        .PREADY(PREADY), .PRDATA(PRDATA), .PSLVERR(PSLVERR)
    );

    // 10 ns clock
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Inputs change 2 ns after the rising edge; checks follow 1 ns later
    task automatic next_cycle();
        @(posedge PCLK);
        #2;
    endtask

    // Absolute bound on the run
    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        PRESETn = 1'b0;
        {req0_valid, req0_write, req1_valid, req1_write} = 4'b0000;
        req0_addr = 32'h0; req0_wdata = 32'h0; req0_strb = 4'h0; req0_prot = 3'b000;
        req1_addr = 32'h0; req1_wdata = 32'h0; req1_strb = 4'h0; req1_prot = 3'b000;
        PREADY = 1'b1; PSLVERR = 1'b0; PRDATA = 32'h0;
        #1;
        check("rst_psel", PSEL, 1'b0);
        check("rst_penable", PENABLE, 1'b0);
        check("rst_pwrite", PWRITE, 1'b0);
        check("rst_paddr", PADDR, 32'h0);
        check("rst_pwdata", PWDATA, 32'h0);
        check("rst_pstrb", PSTRB, 4'h0);
        check("rst_rsp0", {rsp0_valid, rsp0_err, rsp0_rdata}, 34'h0);
        check("rst_rsp1", {rsp1_valid, rsp1_err, rsp1_rdata}, 34'h0);
        check("rst_ready", {req0_ready, req1_ready}, 2'b00);
        next_cycle();
        next_cycle();
        PRESETn = 1'b1;

        // Single write, accept on the first edge after reset release
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h10;
        req0_wdata = 32'hDEADBEEF; req0_strb = 4'hF; req0_prot = 3'b010;
        #1;
        check("wr_ready", {req0_ready, req1_ready}, 2'b10);
        next_cycle();
        req0_valid = 1'b0;
        #1;
        check("wr_setup", {PSEL, PENABLE, PWRITE}, 3'b101);
        check("wr_paddr", PADDR, 32'h10);
        check("wr_pwdata", PWDATA, 32'hDEADBEEF);
        check("wr_pstrb_pprot", {PSTRB, PPROT}, {4'hF, 3'b010});
        next_cycle();
        #1;
        check("wr_access", {PSEL, PENABLE}, 2'b11);
        check("wr_no_rsp_yet", rsp0_valid, 1'b0);
        next_cycle();
        #1;
        check("wr_rsp", {rsp0_valid, rsp0_err, rsp0_rdata, rsp1_valid}, {1'b1, 1'b0, 32'h0, 1'b0});
        check("wr_idle", {PSEL, PENABLE}, 2'b00);
        check("wr_hold_paddr", PADDR, 32'h10);
        next_cycle();
        #1;
        check("wr_rsp_pulse", rsp0_valid, 1'b0);

        // Contention: both requesters issue three reads each
        PRESETn = 1'b0;
        next_cycle();
        PRESETn = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h100; req0_strb = 4'hF;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h200; req1_strb = 4'hF;
        cnt0 = 0; cnt1 = 0;
        for (int i = 0; i < 6; i++) begin
            g = i % 2;
            #1;
            check("cont_grant", {req0_ready, req1_ready}, (g == 0) ? 2'b10 : 2'b01);
            if (i > 0) begin
                check("cont_rsp_valid", {rsp0_valid, rsp1_valid}, (g == 0) ? 2'b01 : 2'b10);
                check("cont_rsp_rdata", (g == 0) ? rsp1_rdata : rsp0_rdata, 32'hA5A5_0000 + 32'(i));
            end
            next_cycle();
            if (g == 0) begin
                cnt0++;
                if (cnt0 == 3) req0_valid = 1'b0;
            end else begin
                cnt1++;
                if (cnt1 == 3) req1_valid = 1'b0;
            end
            #1;
            check("cont_setup", {PSEL, PENABLE, PWRITE, PSTRB}, {3'b100, 4'h0});
            check("cont_paddr", PADDR, (g == 0) ? 32'h100 : 32'h200);
            check("cont_ready_low", {req0_ready, req1_ready}, 2'b00);
            next_cycle();
            PRDATA = 32'hA5A5_0001 + 32'(i);
            #1;
            check("cont_access", {PSEL, PENABLE}, 2'b11);
            next_cycle();
        end
        #1;
        check("cont_last_rsp", {rsp0_valid, rsp1_valid, rsp1_err}, 3'b010);
        check("cont_last_rdata", rsp1_rdata, 32'hA5A5_0006);

        // Wait states: three PREADY-low ACCESS cycles, then PSLVERR
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h300;
        PREADY = 1'b0;
        #1;
        check("ws_ready", {req0_ready, req1_ready}, 2'b01);
        next_cycle();
        req1_valid = 1'b0;
        next_cycle();
        for (int k = 0; k < 3; k++) begin
            #1;
            check("ws_paddr_stable", PADDR, 32'h300);
            check("ws_penable_stable", {PSEL, PENABLE}, 2'b11);
            check("ws_no_rsp", rsp1_valid, 1'b0);
            next_cycle();
        end
        PREADY = 1'b1; PSLVERR = 1'b1; PRDATA = 32'h1234_5678;
        #1;
        check("ws_last_access", {PSEL, PENABLE, rsp1_valid}, 3'b110);
        next_cycle();
        PSLVERR = 1'b0;
        #1;
        check("ws_rsp", {rsp1_valid, rsp1_err, rsp0_valid}, 3'b110);
        check("ws_rdata", rsp1_rdata, 32'h1234_5678);
        check("ws_idle", PSEL, 1'b0);

        // Timeout: PREADY held low for the whole ACCESS phase
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h400;
        PREADY = 1'b0; PRDATA = 32'hFFFF_FFFF;
        #1;
        check("to_ready", req0_ready, 1'b1);
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        for (int k = 0; k < 16; k++) begin
            #1;
            check("to_psel_held", {PSEL, PENABLE, rsp0_valid}, 3'b110);
            next_cycle();
        end
        #1;
        check("to_psel_drop", {PSEL, PENABLE}, 2'b00);
        check("to_rsp", {rsp0_valid, rsp0_err, rsp0_rdata}, {2'b11, 32'h0});
        PREADY = 1'b1;
        req0_valid = 1'b1; req0_write = 1'b1; req0_addr = 32'h500;
        req0_wdata = 32'h0000_0011; req0_strb = 4'h3;
        #1;
        check("to_next_ready", req0_ready, 1'b1);
        next_cycle();
        req0_valid = 1'b0;
        #1;
        check("to_next_setup", {PSEL, PENABLE, PWRITE, PSTRB}, {3'b101, 4'h3});
        check("to_next_pwdata", PWDATA, 32'h0000_0011);
        next_cycle();
        next_cycle();
        #1;
        check("to_next_rsp", {rsp0_valid, rsp0_err, rsp0_rdata}, {2'b10, 32'h0});

        // Reset during ACCESS aborts without a response
        req0_valid = 1'b1; req0_write = 1'b0; req0_addr = 32'h600;
        PREADY = 1'b0;
        next_cycle();
        req0_valid = 1'b0;
        next_cycle();
        #1;
        check("ra_in_access", {PSEL, PENABLE}, 2'b11);
        PRESETn = 1'b0;
        #1;
        check("ra_abort", {PSEL, PENABLE}, 2'b00);
        check("ra_paddr_clr", PADDR, 32'h0);
        next_cycle();
        #1;
        check("ra_no_rsp", {rsp0_valid, rsp1_valid}, 2'b00);
        PREADY = 1'b1; PRDATA = 32'hCAFE_0001;
        PRESETn = 1'b1;
        req1_valid = 1'b1; req1_write = 1'b0; req1_addr = 32'h700;
        #1;
        check("ra_req1_alone", {req0_ready, req1_ready}, 2'b01);
        req0_valid = 1'b1;
        #1;
        check("ra_ptr_reset", {req0_ready, req1_ready}, 2'b10);
        next_cycle();
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
        check("ra_setup_paddr", PADDR, 32'h600);
        next_cycle();
        next_cycle();
        #1;
        check("ra_rsp", {rsp0_valid, rsp1_valid, rsp0_err}, 3'b100);
        check("ra_rdata", rsp0_rdata, 32'hCAFE_0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
